// File: rtl/sata_host_oob.sv
// sata_host_oob: SATA host OOB sequencer (COMRESET/COMINIT/COMWAKE, ALIGN handshake) with ALIGN insertion in Ready.
// Define OOB_DEBUG_EN to enable the registered dbg capture bus and trig_o.
module sata_host_oob #(
  parameter logic [15:0] C_TIMEOUT   = 16'hFFFF,
  parameter logic [15:0] C_BURST_LEN = 16'h0288
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         StartComm,
  output logic         CommInit,
  output logic         link_up,
  output logic         txcomstart,
  output logic         txcomtype,
  output logic         txelecidle,
  output logic         rxreset,
  output logic [31:0]  txdata,
  output logic [3:0]   txdatak,
  input  logic [31:0]  txdata_ll,
  input  logic         txdatak_ll,
  output logic         txdatak_pop,
  input  logic [2:0]   rxstatus,
  input  logic         rxbyteisaligned,
  input  logic         rxelecidle,
  input  logic         plllkdet,
  input  logic         tx_sync_done,
  input  logic [31:0]  rxdata,
  input  logic [3:0]   rxdatak,
  input  logic [31:0]  gtx_tune,
  input  logic         trig_i,
  output logic         trig_o,
  output logic [127:0] dbg
);
  localparam logic [3:0] S_IDLE             = 4'd0;
  localparam logic [3:0] S_RESET            = 4'd1;
  localparam logic [3:0] S_AWAIT_COMINIT    = 4'd2;
  localparam logic [3:0] S_AWAIT_NO_COMINIT = 4'd3;
  localparam logic [3:0] S_CALIBRATE        = 4'd4;
  localparam logic [3:0] S_COMWAKE          = 4'd5;
  localparam logic [3:0] S_AWAIT_COMWAKE    = 4'd6;
  localparam logic [3:0] S_AWAIT_NO_COMWAKE = 4'd7;
  localparam logic [3:0] S_AWAIT_ALIGN      = 4'd8;
  localparam logic [3:0] S_ADJUST_SPEED     = 4'd9;
  localparam logic [3:0] S_SEND_ALIGN       = 4'd10;
  localparam logic [3:0] S_READY            = 4'd11;
  localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
  logic [3:0]  state, next_state;
  logic [15:0] count;
  logic        sc_s1, sc_s2;
  logic [2:0]  na_sr;
  logic [7:0]  align_cnt;
  logic        phy_ready, burst_done, timeout, align_det, nonalign, na_det, align_req, cnt_en, pass_ll;
  assign phy_ready   = plllkdet & tx_sync_done;
  assign burst_done  = (count == C_BURST_LEN) | rxstatus[0];
  assign timeout     = (count == C_TIMEOUT);
  assign align_det   = rxbyteisaligned & ((rxdatak[0] & (rxdata == 32'h7B4A4ABC)) |
                                          (rxdatak[1] & (rxdata == 32'h4A4ABC7B)) |
                                          (rxdatak[2] & (rxdata == 32'h4ABC7B4A)) |
                                          (rxdatak[3] & (rxdata == 32'hBC7B4A4A)));
  assign nonalign    = rxbyteisaligned & ((rxdatak[0] & (rxdata[7:0]   == 8'h7C)) |
                                          (rxdatak[1] & (rxdata[15:8]  == 8'h7C)) |
                                          (rxdatak[2] & (rxdata[23:16] == 8'h7C)) |
                                          (rxdatak[3] & (rxdata[31:24] == 8'h7C)));
  assign na_det      = &na_sr;
  assign align_req   = ((align_cnt == 8'h00) | (align_cnt == 8'hFF)) & ~txdatak_ll;
  assign txdatak_pop = ~align_req;
  assign pass_ll     = (state == S_READY) & ~align_req;
  assign CommInit    = rxstatus[2];
  assign rxreset     = 1'b0;
  assign cnt_en      = (next_state == state) & (state inside {S_RESET, S_AWAIT_COMINIT, S_COMWAKE, S_AWAIT_COMWAKE, S_AWAIT_ALIGN});
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:             next_state = phy_ready ? S_RESET : state;
      S_RESET:            next_state = burst_done ? S_AWAIT_COMINIT : state;
      S_AWAIT_COMINIT:    next_state = rxstatus[2] ? S_AWAIT_NO_COMINIT : timeout ? S_IDLE : state;
      S_AWAIT_NO_COMINIT: next_state = rxstatus[2] ? state : S_CALIBRATE;
      S_CALIBRATE:        next_state = S_COMWAKE;
      S_COMWAKE:          next_state = !burst_done ? state : rxstatus[1] ? S_AWAIT_NO_COMWAKE : S_AWAIT_COMWAKE;
      S_AWAIT_COMWAKE:    next_state = rxstatus[1] ? S_AWAIT_NO_COMWAKE : timeout ? S_IDLE : state;
      S_AWAIT_NO_COMWAKE: next_state = rxstatus[1] ? state : S_AWAIT_ALIGN;
      S_AWAIT_ALIGN:      next_state = align_det ? S_ADJUST_SPEED : timeout ? S_IDLE : state;
      S_ADJUST_SPEED:     next_state = S_SEND_ALIGN;
      S_SEND_ALIGN:       next_state = na_det ? S_READY : state;
      S_READY:            next_state = rxelecidle ? S_IDLE : state;
      default:            next_state = S_IDLE;
    endcase
    if (sc_s2) next_state = S_IDLE;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      count     <= 16'd0;
      sc_s1     <= 1'b0;
      sc_s2     <= 1'b0;
      na_sr     <= 3'b000;
      align_cnt <= 8'd1;
    end else begin
      state     <= next_state;
      count     <= cnt_en ? count + 16'd1 : 16'd0;
      sc_s1     <= StartComm;
      sc_s2     <= sc_s1;
      na_sr     <= {na_sr[1:0], nonalign & (state == S_SEND_ALIGN)};
      align_cnt <= ((state != S_READY) | txdatak_ll) ? 8'd1 : gtx_tune[31] ? align_cnt + 8'd1 : align_cnt;
    end
  // Control outputs follow the state one cycle late; Calibrate/AdjustSpeed keep prior values.
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      txelecidle <= 1'b0;
      txcomstart <= 1'b0;
      txcomtype  <= 1'b0;
      link_up    <= 1'b0;
      txdata     <= ALIGN;
      txdatak    <= 4'b0001;
    end else begin
      case (state)
        S_IDLE: begin
          txelecidle <= 1'b0;
          txcomtype  <= 1'b0;
          txcomstart <= 1'b0;
          link_up    <= 1'b0;
        end
        S_RESET: begin
          txelecidle <= 1'b1;
          txcomtype  <= 1'b0;
          txcomstart <= 1'b1;
        end
        S_AWAIT_COMINIT, S_AWAIT_NO_COMINIT, S_AWAIT_COMWAKE, S_AWAIT_NO_COMWAKE: begin
          txelecidle <= 1'b1;
          txcomstart <= 1'b0;
        end
        S_COMWAKE: begin
          txelecidle <= 1'b1;
          txcomtype  <= 1'b1;
          txcomstart <= 1'b1;
        end
        S_AWAIT_ALIGN, S_SEND_ALIGN: begin
          txelecidle <= 1'b0;
          txcomstart <= 1'b0;
        end
        S_READY: begin
          txelecidle <= 1'b0;
          link_up    <= 1'b1;
        end
        default: ;
      endcase
      txdata  <= (state == S_AWAIT_ALIGN) ? 32'h4A4A4A4A : pass_ll ? txdata_ll : ALIGN;
      txdatak <= {3'b000, (state == S_AWAIT_ALIGN) ? 1'b0 : pass_ll ? txdatak_ll : 1'b1};
    end
  logic unused_ok;
`ifdef OOB_DEBUG_EN
  assign unused_ok = ^gtx_tune[30:0];
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      dbg    <= 128'd0;
      trig_o <= 1'b0;
    end else begin
      dbg    <= {trig_i, ~sys_rst_n, plllkdet, 1'b0, align_det, rxreset, link_up, rxbyteisaligned,
                 na_det, tx_sync_done, sc_s2, rxelecidle, phy_ready, txelecidle, txcomtype, txcomstart,
                 5'd0, rxstatus, count, 4'd0, state, 4'd0, txdatak, 4'd0, rxdatak, txdata, rxdata};
      trig_o <= trig_i & (state == S_READY);
    end
`else
  assign unused_ok = ^{gtx_tune[30:0], trig_i};
  assign dbg       = 128'd0;
  assign trig_o    = 1'b0;
`endif
endmodule

// File: tb/tb_sata_host_oob.sv
// tb_sata_host_oob: directed self-checking bench for sata_host_oob (default build, reduced C_TIMEOUT).
module tb_sata_host_oob;
  localparam logic [15:0] TO = 16'h0400;
  localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
  localparam logic [3:0] S_IDLE = 4'd0, S_RESET = 4'd1, S_AWAIT_COMINIT = 4'd2, S_AWAIT_NO_COMINIT = 4'd3,
                         S_CALIBRATE = 4'd4, S_COMWAKE = 4'd5, S_AWAIT_COMWAKE = 4'd6, S_AWAIT_NO_COMWAKE = 4'd7,
                         S_AWAIT_ALIGN = 4'd8, S_ADJUST_SPEED = 4'd9, S_SEND_ALIGN = 4'd10, S_READY = 4'd11;
  logic         sys_clk, sys_rst_n, StartComm, CommInit, link_up, txcomstart, txcomtype, txelecidle, rxreset;
  logic [31:0]  txdata, txdata_ll, rxdata, gtx_tune;
  logic [3:0]   txdatak, rxdatak;
  logic         txdatak_ll, txdatak_pop, rxbyteisaligned, rxelecidle, plllkdet, tx_sync_done, trig_i, trig_o;
  logic [2:0]   rxstatus;
  logic [127:0] dbg;
  int errors = 0, checks = 0, m = 0, n = 0;

  sata_host_oob #(.C_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .StartComm(StartComm), .CommInit(CommInit),
    .link_up(link_up), .txcomstart(txcomstart), .txcomtype(txcomtype), .txelecidle(txelecidle),
    .rxreset(rxreset), .txdata(txdata), .txdatak(txdatak), .txdata_ll(txdata_ll),
    .txdatak_ll(txdatak_ll), .txdatak_pop(txdatak_pop), .rxstatus(rxstatus),
    .rxbyteisaligned(rxbyteisaligned), .rxelecidle(rxelecidle), .plllkdet(plllkdet),
    .tx_sync_done(tx_sync_done), .rxdata(rxdata), .rxdatak(rxdatak), .gtx_tune(gtx_tune),
    .trig_i(trig_i), .trig_o(trig_o), .dbg(dbg)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] tgt, input int max, input string tag, output int cyc);
    cyc = 0;
    while (dut.state !== tgt && cyc < max) begin
      step();
      cyc++;
    end
    chk(tag, dut.state, tgt);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, dut.state, S_IDLE);
    chk({tag, "_count"}, dut.count, 16'd0);
    chk({tag, "_txdata"}, txdata, ALIGN);
    chk({tag, "_txdatak"}, txdatak, 4'b0001);
    chk({tag, "_txelecidle"}, txelecidle, 1'b0);
    chk({tag, "_txcomstart"}, txcomstart, 1'b0);
    chk({tag, "_txcomtype"}, txcomtype, 1'b0);
    chk({tag, "_link_up"}, link_up, 1'b0);
    chk({tag, "_pop"}, txdatak_pop, 1'b1);
    chk({tag, "_trig_o"}, trig_o, 1'b0);
    chk({tag, "_dbg"}, dbg, 128'd0);
  endtask

  task automatic ready_cycle(input int i);
    logic req;
    logic [31:0] d;
    req = (m == 0 || m == 255);
    d = 32'h1000_0000 + i;
    txdata_ll = d;
    chk("ready_pop", txdatak_pop, !req);
    step();
    chk("ready_txdata", txdata, req ? ALIGN : d);
    chk("ready_txdatak", txdatak, req ? 4'b0001 : 4'b0000);
    m = (m + 1) % 256;
  endtask

  initial begin
    sys_rst_n = 0; StartComm = 0; txdata_ll = 32'hDEADBEEF; txdatak_ll = 0; rxstatus = 0;
    rxbyteisaligned = 0; rxelecidle = 0; plllkdet = 0; tx_sync_done = 0; rxdata = 0; rxdatak = 0;
    gtx_tune = 0; trig_i = 0;
    #12;
    chk_reset_vals("rst");
    chk("rxreset", rxreset, 1'b0);
    sys_rst_n = 1; plllkdet = 1; tx_sync_done = 1;
    step();
    chk("idle_to_reset", dut.state, S_RESET);
    step();
    chk("reset_comstart", txcomstart, 1'b1);
    chk("reset_comtype", txcomtype, 1'b0);
    chk("reset_elecidle", txelecidle, 1'b1);
    wait_state(S_AWAIT_COMINIT, 2000, "burst_end", n);
    chk("burst_cycles", n, 32'd648);
    step();
    chk("awcominit_comstart", txcomstart, 1'b0);
    chk("awcominit_elecidle", txelecidle, 1'b1);
    wait_state(S_IDLE, 5000, "cominit_timeout", n);
    chk("timeout_cycles", n, 32'(TO));
    step();
    chk("idle_to_reset2", dut.state, S_RESET);
    chk("idle_elecidle", txelecidle, 1'b0);
    // Burst-done via rxstatus[0], then COMINIT pulse and the COMWAKE exchange.
    rxstatus = 3'b001;
    #1 chk("comminit_lo", CommInit, 1'b0);
    step();
    chk("rxburst_done", dut.state, S_AWAIT_COMINIT);
    rxstatus = 3'b100;
    #1 chk("comminit_hi", CommInit, 1'b1);
    step();
    chk("await_no_cominit", dut.state, S_AWAIT_NO_COMINIT);
    rxstatus = 3'b000;
    step();
    chk("calibrate", dut.state, S_CALIBRATE);
    step();
    chk("comwake", dut.state, S_COMWAKE);
    step();
    chk("comwake_hold", dut.state, S_COMWAKE);
    chk("comwake_comtype", txcomtype, 1'b1);
    chk("comwake_comstart", txcomstart, 1'b1);
    chk("comwake_elecidle", txelecidle, 1'b1);
    rxstatus = 3'b011;
    step();
    chk("await_no_comwake", dut.state, S_AWAIT_NO_COMWAKE);
    rxstatus = 3'b000;
    step();
    chk("await_align", dut.state, S_AWAIT_ALIGN);
    chk("awnocw_comstart", txcomstart, 1'b0);
    chk("awnocw_elecidle", txelecidle, 1'b1);
    step();
    chk("awalign_txdata", txdata, 32'h4A4A4A4A);
    chk("awalign_txdatak", txdatak, 4'b0000);
    chk("awalign_elecidle", txelecidle, 1'b0);
    rxdata = ALIGN; rxdatak = 4'b0001; rxbyteisaligned = 0;
    step();
    chk("align_needs_aligned", dut.state, S_AWAIT_ALIGN);
    rxbyteisaligned = 1;
    step();
    chk("adjust_speed", dut.state, S_ADJUST_SPEED);
    rxdata = 32'h0000007C; rxdatak = 4'b0001;
    gtx_tune = 32'h8000_0000; txdatak_ll = 0; trig_i = 1;
    step();
    chk("send_align", dut.state, S_SEND_ALIGN);
    chk("adjust_txdata", txdata, ALIGN);
    chk("adjust_txdatak", txdatak, 4'b0001);
    step(); step();
    chk("send_align_2", dut.state, S_SEND_ALIGN);
    step();
    chk("send_align_3", dut.state, S_SEND_ALIGN);
    step();
    chk("ready", dut.state, S_READY);
    chk("ready_link_lag", link_up, 1'b0);
    step();
    chk("link_up", link_up, 1'b1);
    chk("first_ll", txdata, 32'hDEADBEEF);
    chk("first_llk", txdatak, 4'b0000);
    chk("trig_o_off", trig_o, 1'b0);
    // align_cnt now 2; walk through 0xFF and 0x00, then back up to 0xFF.
    m = 2;
    for (int i = 0; i < 260; i++) ready_cycle(i);
    for (int i = 0; i < 249; i++) ready_cycle(i + 1000);
    txdatak_ll = 1; txdata_ll = 32'hCAFEF00D;
    #1 chk("k_masks_req", txdatak_pop, 1'b1);
    step();
    chk("k_txdata", txdata, 32'hCAFEF00D);
    chk("k_txdatak", txdatak, 4'b0001);
    txdatak_ll = 0;
    #1 chk("k_reloads_cnt", txdatak_pop, 1'b1);
    StartComm = 1;
    step(); step();
    chk("sc_sync_ready", dut.state, S_READY);
    step();
    chk("sc_idle", dut.state, S_IDLE);
    step();
    chk("sc_link_down", link_up, 1'b0);
    step(); step(); step();
    chk("sc_hold_idle", dut.state, S_IDLE);
    StartComm = 0;
    wait_state(S_RESET, 10, "sc_release", n);
    chk("sc_release_cycles", n, 32'd3);
    // Second bring-up via AwaitCOMWAKE and a byte-rotated ALIGN on lane 2.
    rxbyteisaligned = 0;
    rxstatus = 3'b001;
    wait_state(S_AWAIT_COMINIT, 4, "b2_awcominit", n);
    rxstatus = 3'b100;
    step();
    rxstatus = 3'b000;
    wait_state(S_COMWAKE, 4, "b2_comwake", n);
    rxstatus = 3'b001;
    step();
    chk("b2_await_comwake", dut.state, S_AWAIT_COMWAKE);
    rxstatus = 3'b010;
    step();
    chk("b2_await_no_comwake", dut.state, S_AWAIT_NO_COMWAKE);
    rxstatus = 3'b000;
    wait_state(S_AWAIT_ALIGN, 4, "b2_await_align", n);
    rxdata = 32'h4ABC7B4A; rxdatak = 4'b0100; rxbyteisaligned = 1;
    wait_state(S_ADJUST_SPEED, 3, "b2_adjust", n);
    rxdata = 32'h7C000000; rxdatak = 4'b1000;
    wait_state(S_READY, 8, "b2_ready", n);
    step();
    chk("b2_link_up", link_up, 1'b1);
    rxelecidle = 1;
    step();
    chk("elecidle_idle", dut.state, S_IDLE);
    rxelecidle = 0;
    step();
    chk("elecidle_link_down", link_up, 1'b0);
    rxstatus = 3'b001;
    wait_state(S_AWAIT_COMINIT, 4, "b3_awcominit", n);
    rxstatus = 3'b100;
    step();
    rxstatus = 3'b000;
    wait_state(S_COMWAKE, 4, "b3_comwake", n);
    step();
    chk("b3_comtype", txcomtype, 1'b1);
    #3 sys_rst_n = 0;
    #1 chk_reset_vals("mid_rst");
    #5 sys_rst_n = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sata_host_oob.md
Name: sata_host_oob

Overview:
- SATA host-side OOB/link-initialisation controller (SATA 2.6 §8.4.1) placed between the link layer and a GTX transceiver wrapper.
- Sequences COMRESET/COMINIT/COMWAKE, ALIGN detection and ALIGN handshake, then asserts link_up.
- In Ready, passes link-layer dwords through with periodic ALIGN insertion.
- Contains an internal StartComm synchroniser and an optional debug-capture bus.

Parameters:
- C_TIMEOUT, 16'hFFFF, count value for COMINIT/COMWAKE/ALIGN await timeouts.
- C_BURST_LEN, 16'h0288, count value ending a COMRESET/COMWAKE burst.

Ports:
- sys_clk  in  1  transceiver user clock; the only clock.
- sys_rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- StartComm  in  1  async request to restart OOB.
- CommInit  out  1  equals rxstatus[2], combinational.
- link_up  out  1  link ready.
- txcomstart  out  1  start OOB burst.
- txcomtype  out  1  burst type: 0 = COMRESET, 1 = COMWAKE.
- txelecidle  out  1  TX electrical idle.
- rxreset  out  1  tied 0.
- txdata  out  32  TX dword.
- txdatak  out  4  TX K flags; only bit 0 is used, bits 3:1 are 0.
- txdata_ll  in  32  link-layer dword.
- txdatak_ll  in  1  link-layer K flag.
- txdatak_pop  out  1  link-layer dword consumed.
- rxstatus  in  3  bit0 = burst done, bit1 = COMWAKE det, bit2 = COMINIT det.
- rxbyteisaligned, rxelecidle, plllkdet, tx_sync_done  in  1 each.
- rxdata  in  32  RX dword.
- rxdatak  in  4  RX K flags.
- gtx_tune  in  32  bit31 enables ALIGN insertion.
- trig_i  in  1  debug trigger in.
- trig_o  out  1  debug trigger out.
- dbg  out  128  debug bus.

Behaviour:
- Reset values:
  - state IDLE; count 0.
  - txelecidle, txcomstart, txcomtype, link_up, trig_o all 0; dbg 0.
  - txdata 32'h7B4A4ABC; txdatak 4'b0001.
  - align_cnt 1.
- StartComm:
  - Synchronised by two flops.
  - While the synchronised value is 1, state is held in IDLE.
- phy_ready = plllkdet & tx_sync_done.
- Counter (16 bit):
  - Increments when next state equals current state and the state is Reset, AwaitCOMINIT, COMWAKE, AwaitCOMWAKE or AwaitAlign.
  - Otherwise clears to 0.
  - Never wraps past C_TIMEOUT, because the timeout leaves the state.
- Timing terms:
  - burst_done = (count == C_BURST_LEN) | rxstatus[0].
  - timeout = (count == C_TIMEOUT).
- State transitions (priority as listed):
  - IDLE → Reset when phy_ready.
  - Reset → AwaitCOMINIT when burst_done.
  - AwaitCOMINIT → AwaitNoCOMINIT if rxstatus[2]; else → IDLE if timeout.
  - AwaitNoCOMINIT → Calibrate when rxstatus[2] = 0.
  - Calibrate → COMWAKE unconditionally.
  - COMWAKE, when burst_done: → AwaitNoCOMWAKE if rxstatus[1], else → AwaitCOMWAKE.
  - AwaitCOMWAKE → AwaitNoCOMWAKE if rxstatus[1]; else → IDLE if timeout.
  - AwaitNoCOMWAKE → AwaitAlign when rxstatus[1] = 0.
  - AwaitAlign → AdjustSpeed if align_det; else → IDLE if timeout.
  - AdjustSpeed → SendAlign unconditionally.
  - SendAlign → Ready when nonalign is seen 3 consecutive cycles.
  - Ready → IDLE when rxelecidle.
- align_det:
  - Requires rxbyteisaligned.
  - Matches any of: (rxdatak[0] & rxdata == 7B4A4ABC), (rxdatak[1] & rxdata == 4A4ABC7B), (rxdatak[2] & rxdata == 4ABC7B4A), (rxdatak[3] & rxdata == BC7B4A4A).
- nonalign:
  - Requires rxbyteisaligned.
  - True when any byte i has rxdatak[i] & byte == 8'h7C.
  - Shifted into a 3-bit register gated by state == SendAlign; detection requires 3'b111.
- Registered TX control outputs (1-cycle latency from state):
  - IDLE: elecidle 0, comtype 0, comstart 0, link_up 0.
  - Reset: elecidle 1, comtype 0, comstart 1.
  - Await states: elecidle 1, comstart 0.
  - COMWAKE: elecidle 1, comtype 1, comstart 1.
  - AwaitAlign / SendAlign: elecidle 0, comstart 0.
  - Ready: elecidle 0, link_up 1.
  - Other states hold their values.
- Registered TX data:
  - AwaitAlign: 4A4A4A4A with K = 0.
  - Ready: ALIGN (7B4A4ABC, K = 1) if align_req, else txdata_ll / txdatak_ll.
  - All other states: ALIGN with K = 1.
- ALIGN insertion:
  - align_cnt (8 bit) is set to 1 when state != Ready or txdatak_ll = 1.
  - Otherwise it increments in Ready when gtx_tune[31] = 1, wrapping 0xFF → 0.
  - align_req = (align_cnt == 0 | align_cnt == 0xFF) & ~txdatak_ll.
  - txdatak_pop = ~align_req.

Optional Feature:
- OOB_DEBUG_EN defined:
  - dbg is registered each cycle with: [31:0] rxdata, [63:32] txdata, [71:64] rxdatak zero-extended, [79:72] txdatak, [87:80] state, [103:88] count, [111:104] rxstatus.
  - [112] txcomstart, [113] txcomtype, [114] txelecidle, [115] phy_ready, [116] rxelecidle, [117] StartComm sync, [118] tx_sync_done, [119] nonalign detect, [120] rxbyteisaligned, [121] link_up, [122] rxreset, [123] align_det, [124] 0, [125] plllkdet, [126] ~sys_rst_n, [127] trig_i.
  - trig_o = registered trig_i & (state == Ready).
- Not defined: dbg and trig_o are constant 0.

Test Plan:
- plllkdet = tx_sync_done = 1, no rxstatus → Reset with txcomstart = 1 and comtype = 0; AwaitCOMINIT after 0x288 cycles; IDLE after 0xFFFF more cycles.
- Pulse rxstatus[2], then rxstatus[1] 1→0 → passes AwaitNoCOMINIT, Calibrate, COMWAKE (comtype = 1), AwaitNoCOMWAKE, AwaitAlign; txdata = 4A4A4A4A with K = 0.
- rxdata = 7B4A4ABC, rxdatak = 0001, aligned → AdjustSpeed then SendAlign; then rxdata byte0 = 7C with K for 3 cycles → Ready and link_up = 1 next cycle.
- In Ready, gtx_tune[31] = 1, txdatak_ll = 0 → ALIGN inserted and txdatak_pop = 0 whenever align_cnt hits 0xFF or 0; otherwise txdata = txdata_ll.
- Assert StartComm mid-Ready → IDLE within 3 cycles, link_up = 0; rxelecidle = 1 in Ready → IDLE.
- sys_rst_n low mid-COMWAKE → all outputs return to reset values immediately.
